// File: rtl/i2s_tx_if.sv
// Sample stream into the I2S transmitter: one word per valid/ready handshake.
interface i2s_tx_if;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;

    modport master (output sample_in, output sample_valid, input sample_ready);
    modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_tx.sv
// Mono-to-stereo I2S transmitter: one buffered Q1.15 word per 32-bit frame,
// duplicated into both slots, with frame_start pacing and underrun reporting.
module i2s_tx #(
    parameter int BCLK_DIV = 4
) (
    input  logic      clk,
    input  logic      reset,
    i2s_tx_if.slave   s_if,
    output logic      bclk,
    output logic      lrclk,
    output logic      sdata,
    output logic      frame_start,
    output logic      underrun
);
    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

    logic [7:0]  div_cnt_q, div_cnt_d;
    logic        bclk_q, bclk_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        lrclk_q, lrclk_d;
    logic [31:0] shreg_q, shreg_d;
    logic        sdata_q, sdata_d;
    logic        full_q, full_d;
    logic [15:0] sample_buf_q, sample_buf_d;
    logic        frame_start_q, frame_start_d;
    logic        underrun_q, underrun_d;

    logic accept;
    logic fall;

    assign s_if.sample_ready = !full_q;
    assign accept            = s_if.sample_valid && !full_q;

    // NOTE: every variable gets its default first so no path leaves one
    // unassigned; otherwise always_comb would infer a latch.
    always_comb begin
        div_cnt_d     = div_cnt_q;
        bclk_d        = bclk_q;
        bit_cnt_d     = bit_cnt_q;
        lrclk_d       = lrclk_q;
        shreg_d       = shreg_q;
        sdata_d       = sdata_q;
        full_d        = full_q;
        sample_buf_d  = sample_buf_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        fall          = 1'b0;

        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = 8'd0;
            bclk_d    = !bclk_q;
            fall      = bclk_q;
        end else begin
            div_cnt_d = div_cnt_q + 8'd1;
        end

        if (accept) begin
            sample_buf_d = s_if.sample_in;
            full_d       = 1'b1;
        end

        if (fall) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            // Word select flips one BCLK ahead of each slot's MSB.
            if (bit_cnt_d == 5'd15) begin
                lrclk_d = 1'b1;
            end else if (bit_cnt_d == 5'd31) begin
                lrclk_d = 1'b0;
            end

            if (bit_cnt_q == 5'd31) begin
                frame_start_d = 1'b1;
                if (full_q) begin
                    shreg_d = {sample_buf_q, sample_buf_q};
                    full_d  = 1'b0;
                end else begin
                    // Empty buffer: send silence; a word accepted now waits
                    // for the next frame.
                    shreg_d    = 32'd0;
                    underrun_d = 1'b1;
                end
            end else begin
                shreg_d = {shreg_q[30:0], 1'b0};
            end
            sdata_d = shreg_d[31];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values computed before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q     <= 8'd0;
            bclk_q        <= 1'b0;
            bit_cnt_q     <= 5'd31;
            lrclk_q       <= 1'b0;
            shreg_q       <= 32'd0;
            sdata_q       <= 1'b0;
            full_q        <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            bclk_q        <= bclk_d;
            bit_cnt_q     <= bit_cnt_d;
            lrclk_q       <= lrclk_d;
            shreg_q       <= shreg_d;
            sdata_q       <= sdata_d;
            full_q        <= full_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    // NOTE: the data word needs no reset; full_q alone decides whether it is
    // ever used, so a stale value can never reach sdata.
    always_ff @(posedge clk) begin
        sample_buf_q <= sample_buf_d;
    end

    assign bclk        = bclk_q;
    assign lrclk       = lrclk_q;
    assign sdata       = sdata_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;
endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: two instances (BCLK_DIV 4 and 2) driven from a
// transaction-level model of buffer, frame timing and I2S serial layout.
module tb_i2s_tx;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    i2s_tx_if sif0 ();
    i2s_tx_if sif1 ();

    wire [1:0] bclk_w, lrclk_w, sdata_w, fs_w, ur_w;

    i2s_tx #(.BCLK_DIV(4)) dut0 (
        .clk(clk), .reset(rst), .s_if(sif0),
        .bclk(bclk_w[0]), .lrclk(lrclk_w[0]), .sdata(sdata_w[0]),
        .frame_start(fs_w[0]), .underrun(ur_w[0])
    );

    i2s_tx #(.BCLK_DIV(2)) dut1 (
        .clk(clk), .reset(rst), .s_if(sif1),
        .bclk(bclk_w[1]), .lrclk(lrclk_w[1]), .sdata(sdata_w[1]),
        .frame_start(fs_w[1]), .underrun(ur_w[1])
    );

    typedef struct {
        int          at;
        logic [31:0] frame;
        logic        ur;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    bit          model_full[2];
    logic [15:0] model_buf[2];
    int          edge_n[2];
    int          frames_done[2];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int div_of(input int idx);
        return (idx == 0) ? 4 : 2;
    endfunction

    // Loads happen every 64*D clk edges, the first 2*D edges after reset.
    function automatic bit next_is_load(input int idx);
        int d = div_of(idx);
        int e = edge_n[idx] + 1;
        return (e >= 2 * d) && (((e - 2 * d) % (64 * d)) == 0);
    endfunction

    function automatic int next_pos(input int idx);
        int d = div_of(idx);
        int e = edge_n[idx] + 1;
        return (e < 2 * d) ? -1 : ((e - 2 * d) % (64 * d));
    endfunction

    task automatic model_edge(input int idx, input bit v, input logic [15:0] d);
        exp_t x;
        bit   acc;
        if (rst) begin
            edge_n[idx]     = 0;
            model_full[idx] = 1'b0;
            return;
        end
        acc = v && !model_full[idx];
        if (next_is_load(idx)) begin
            x.at    = cyc + 1;
            x.ur    = !model_full[idx];
            x.frame = model_full[idx] ? {model_buf[idx], model_buf[idx]} : 32'h0;
            if (idx == 0) q0.push_back(x);
            else          q1.push_back(x);
            model_full[idx] = 1'b0;
        end
        if (acc) begin
            model_buf[idx]  = d;
            model_full[idx] = 1'b1;
        end
        edge_n[idx]++;
    endtask

    task automatic step(input bit v0, input logic [15:0] d0, input bit v1, input logic [15:0] d1);
        sif0.sample_valid = v0;
        sif0.sample_in    = d0;
        sif1.sample_valid = v1;
        sif1.sample_in    = d1;
        check("ready0", sif0.sample_ready, !model_full[0]);
        check("ready1", sif1.sample_ready, !model_full[1]);
        model_edge(0, v0, d0);
        model_edge(1, v1, d1);
        @(negedge clk);
    endtask

    task automatic monitor(input int idx);
        int          d = div_of(idx);
        exp_t        x;
        logic [31:0] data_cap;
        logic [31:0] lr_cap;
        int          glitch;
        bit          aborted;
        int          b;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (fs_w[idx]) begin
                if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
                    check($sformatf("unexpected_frame%0d", idx), fs_w[idx], 0);
                    continue;
                end
                if (idx == 0) x = q0.pop_front();
                else          x = q1.pop_front();
                check($sformatf("frame_time%0d", idx), cyc, x.at);
                check($sformatf("underrun%0d", idx), ur_w[idx], x.ur);
                data_cap = '0;
                lr_cap   = '0;
                glitch   = 0;
                aborted  = 1'b0;
                for (int c = 0; c < 64 * d; c++) begin
                    if (c > 0) begin
                        @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (fs_w[idx] || ur_w[idx]) glitch++;
                    end
                    b = 31 - c / (2 * d);
                    if (bclk_w[idx] !== ((c % (2 * d)) >= d)) glitch++;
                    if (c % (2 * d) == 0) begin
                        data_cap[b] = sdata_w[idx];
                        lr_cap[b]   = lrclk_w[idx];
                    end else if (sdata_w[idx] !== data_cap[b] || lrclk_w[idx] !== lr_cap[b]) begin
                        glitch++;
                    end
                end
                if (!aborted) begin
                    check($sformatf("frame_data%0d", idx), data_cap, x.frame);
                    check($sformatf("lrclk_pattern%0d", idx), lr_cap, 32'h0001_FFFE);
                    check($sformatf("timing_glitches%0d", idx), glitch, 0);
                    frames_done[idx]++;
                end
            end else if (ur_w[idx]) begin
                check($sformatf("underrun_without_frame%0d", idx), ur_w[idx], 0);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "0"}, {bclk_w[0], lrclk_w[0], sdata_w[0], fs_w[0], ur_w[0], sif0.sample_ready}, 6'b000001);
        check({tag, "1"}, {bclk_w[1], lrclk_w[1], sdata_w[1], fs_w[1], ur_w[1], sif1.sample_ready}, 6'b000001);
    endtask

    logic [15:0] w0, w1;
    bit          acc0, acc1;
    int          guard;
    int          overdue;

    initial begin
        rst               = 1'b1;
        sif0.sample_valid = 1'b0;
        sif0.sample_in    = '0;
        sif1.sample_valid = 1'b0;
        sif1.sample_in    = '0;
        fork
            monitor(0);
            monitor(1);
        join_none
        @(negedge clk);
        repeat (3) step(0, 0, 0, 0);
        check_reset_outputs("reset_state");
        rst = 1'b0;

        // Word pushed right after reset lands in the first frame; later frames underrun.
        step(1, 16'h8001, 1, 16'h7FFF);
        repeat (2 * 256 + 20) step(0, 0, 0, 0);

        // Random traffic.
        repeat (1500) step($urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 1) == 1, 16'($urandom));

        // Continuous valid with incrementing words: one acceptance per frame.
        w0 = 16'h0100;
        w1 = 16'h0200;
        repeat (1100) begin
            acc0 = !model_full[0];
            acc1 = !model_full[1];
            step(1, w0, 1, w1);
            if (acc0) w0++;
            if (acc1) w1++;
        end

        // Valid arrives exactly on an empty-buffer load.
        guard = 0;
        while ((model_full[0] || !next_is_load(0)) && guard < 2000) begin
            step(0, 0, 0, 0);
            guard++;
        end
        if (guard >= 2000) check("load_wait_timeout", guard, 0);
        step(1, 16'h1234, 0, 0);
        repeat (2 * 256 + 10) step(0, 0, 0, 0);

        // Buffer a word, then reset in the middle of bit 20.
        guard = 0;
        while (!next_is_load(0) && guard < 2000) begin
            step(0, 0, 0, 0);
            guard++;
        end
        step(0, 0, 0, 0);
        step(1, 16'hABCD, 0, 0);
        while (next_pos(0) != 20 * 8 + 3 && guard < 4000) begin
            step(0, 0, 0, 0);
            guard++;
        end
        if (guard >= 4000) check("reset_point_timeout", guard, 0);
        rst = 1'b1;
        step(0, 0, 0, 0);
        check_reset_outputs("mid_frame_reset");
        step(0, 0, 0, 0);
        rst = 1'b0;
        repeat (2 * 256 + 20) step(0, 0, 0, 0);

        overdue = 0;
        foreach (q0[i]) if (q0[i].at < cyc) overdue++;
        foreach (q1[i]) if (q1[i].at < cyc) overdue++;
        check("overdue_frames", overdue, 0);
        check("frames_seen0", frames_done[0] >= 10, 1);
        check("frames_seen1", frames_done[1] >= 20, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001: Parameter BCLK_DIV, default 4: the number of clk cycles per BCLK half-period; legal values are 2 to 255.
REQ-002: clk  input  1  system clock; every register is clocked on the rising edge; the block has a single clock domain.
REQ-003: reset  input  1  synchronous, active-high reset.
REQ-004: sample_in  input  16  signed Q1.15 audio word from the filter output (filtered_output).
REQ-005: sample_valid  input  1  sample_in holds a word to transfer this cycle.
REQ-006: sample_ready  output  1  the holding buffer is empty; a word is accepted when sample_valid and sample_ready are both high.
REQ-007: bclk  output  1  serial bit clock to the DAC.
REQ-008: lrclk  output  1  word select: 0 selects the left slot, 1 selects the right slot.
REQ-009: sdata  output  1  serial data, MSB first, two's complement.
REQ-010: frame_start  output  1  one-cycle pulse on every frame load; this pulse paces the upstream filter.
REQ-011: underrun  output  1  one-cycle pulse when a frame loads while the holding buffer is empty.

Function
REQ-012: Divider: div_cnt counts from 0 to BCLK_DIV-1; when div_cnt equals BCLK_DIV-1, bclk toggles and div_cnt returns to 0.
REQ-013: A "falling event" is the clk edge on which bclk changes from 1 to 0; all of bit_cnt, lrclk, the shift register and sdata update only on falling events.
REQ-014: bit_cnt (5 bits) increments on every falling event and wraps from 31 to 0; one frame is 32 BCLK periods, which is 64*BCLK_DIV clk cycles.
REQ-015: On the falling event that sets bit_cnt to 0, the block loads the frame: shreg[31:0] = {buf, buf} (the mono word is duplicated to the L and R slots), the buffer is marked empty, and frame_start pulses.
REQ-016: On every other falling event, shreg shifts left by 1 with 0 shifted in; sdata = shreg[31] at all times, registered.
REQ-017: lrclk goes to 1 on the falling event that sets bit_cnt to 15, and goes to 0 on the falling event that sets bit_cnt to 31; lrclk therefore leads each slot's MSB by one BCLK (I2S format).
REQ-018: Holding buffer: one 16-bit entry plus a full flag; sample_ready = !full, driven combinationally from the flag.
REQ-019: Accept: when sample_valid && sample_ready, buf is written with sample_in and full is set on the next edge.
REQ-020: Simultaneous load and accept while the buffer is empty: the frame loads zeros, underrun pulses, and the accepted word is kept in the buffer for the next frame.
REQ-021: A load while the buffer is full with a simultaneous accept cannot occur, because sample_ready is low.
REQ-022: Underrun: a load while the buffer is empty loads shreg = 0, pulses underrun in the same cycle as frame_start, and leaves the buffer empty.
REQ-023: No sample loss: a word that is accepted always appears in exactly one frame.
REQ-024: Latency: a word accepted before a load event appears as the left-slot MSB on sdata starting at that load event.

Reset
REQ-025: While reset is high, on each clk edge: div_cnt=0, bclk=0, bit_cnt=31, lrclk=0, shreg=0, sdata=0, buffer empty, frame_start=0, underrun=0.
REQ-026: sample_ready is 1 during and immediately after reset.
REQ-027: The first falling event after reset deasserts occurs 2*BCLK_DIV cycles after deassertion, and it is a frame load.
REQ-028: Reset asserted mid-frame discards the frame in progress and the buffered word; no frame_start or underrun pulse is generated by reset.

Verification (BCLK_DIV=4)
REQ-029: Reset, then idle with no valid -> first load at cycle 8; frame_start=1, underrun=1, sdata=0 for the full 256-cycle frame; bclk period is 8 cycles.
REQ-030: Push 0x8001 right after reset -> sample_ready drops the next cycle; the sdata bits of the frame are 1000000000000001 twice; lrclk=1 during bit_cnt 15..30; ready returns to 1 at the load.
REQ-031: Hold sample_valid=1 with an incrementing word -> exactly one acceptance per frame; consecutive frames carry consecutive words; underrun never pulses after the first frame.
REQ-032: Assert valid exactly on the cycle of an empty-buffer load with 0x1234 -> that frame is zeros with underrun=1; the next frame carries 0x1234 in both slots.
REQ-033: Assert reset at bit_cnt=20 with the buffer full -> all outputs return to their reset values on the next edge; the buffered word never appears on sdata.
REQ-034: BCLK_DIV=2 and 0x7FFF -> bclk period is 4 cycles; the frame is 128 cycles; the left slot reads 0111111111111111.
